// File: rtl/branch_flag_gen_pkg.sv
// Shared definitions for the branch flag generator and the condition checker:
// flag bit positions inside the packed {V,C,N,Z} nibble and branch funct3 codes.
package branch_flag_gen_pkg;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    // Field order matches FLAG_* positions: v is bit 3, z is bit 0.
    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/branch_flag_gen_half_sub.sv
// Purpose: W-bit adder slice with carry-in/carry-out and zero detect on the sum.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
module half_sub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        zero        = (sum == '0);
    end

endmodule

// File: rtl/branch_flag_gen.sv
// Purpose: compute {V,C,N,Z} of in_a - in_b with a split two-stage subtractor.
// Latency: 2 cycles; one result per cycle; in_ready drops only when both stages hold data and out_ready=0.
module branch_flag_gen
    import branch_flag_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int HALF = XLEN / 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [2:0]      in_funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_flags,
    output logic [2:0]      out_funct3
);

    localparam int UPPER = XLEN - HALF;

    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    logic [HALF-1:0]  lo_diff_q, lo_diff_d;
    logic             lo_cout_q, lo_cout_d;
    logic             lo_zero_q, lo_zero_d;
    logic [UPPER-1:0] a_hi_q, a_hi_d;
    logic [UPPER-1:0] b_hi_q, b_hi_d;
    logic [2:0]       tag_q, tag_d;
    flags_t           flags_q, flags_d;
    logic [2:0]       funct3_q, funct3_d;

    logic             s2_adv, s1_acc, s2_load;
    logic [HALF-1:0]  lo_sum;
    logic             lo_cout, lo_zero;
    logic [UPPER-1:0] hi_sum;
    logic             hi_cout, hi_zero;

    // a - b is formed as a + ~b + 1; the +1 enters at the low slice carry-in.
    half_sub #(.W(HALF)) u_sub_lo (
        .a    (in_a[HALF-1:0]),
        .b    (~in_b[HALF-1:0]),
        .cin  (1'b1),
        .sum  (lo_sum),
        .cout (lo_cout),
        .zero (lo_zero)
    );

    half_sub #(.W(UPPER)) u_sub_hi (
        .a    (a_hi_q),
        .b    (~b_hi_q),
        .cin  (lo_cout_q),
        .sum  (hi_sum),
        .cout (hi_cout),
        .zero (hi_zero)
    );

    // The low half of R is carried for observability; the flags need only its zero bit.
    logic unused_lo_diff;
    assign unused_lo_diff = ^lo_diff_q;

    always_comb begin
        s2_adv   = ~s2_vld_q | out_ready;
        in_ready = ~s1_vld_q | s2_adv;
        s1_acc   = in_valid & in_ready;
        s2_load  = s2_adv & s1_vld_q;

        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (s1_acc) begin
                s1_vld_d = 1'b1;
            end else if (s2_adv) begin
                s1_vld_d = 1'b0;
            end
            if (s2_adv) begin
                s2_vld_d = s1_vld_q;
            end
        end

        lo_diff_d = lo_diff_q;
        lo_cout_d = lo_cout_q;
        lo_zero_d = lo_zero_q;
        a_hi_d    = a_hi_q;
        b_hi_d    = b_hi_q;
        tag_d     = tag_q;
        if (s1_acc) begin
            lo_diff_d = lo_sum;
            lo_cout_d = lo_cout;
            lo_zero_d = lo_zero;
            a_hi_d    = in_a[XLEN-1:HALF];
            b_hi_d    = in_b[XLEN-1:HALF];
            tag_d     = in_funct3;
        end

        flags_d  = flags_q;
        funct3_d = funct3_q;
        if (s2_load) begin
            flags_d.v = (a_hi_q[UPPER-1] != b_hi_q[UPPER-1]) &&
                        (hi_sum[UPPER-1] != a_hi_q[UPPER-1]);
            flags_d.c = hi_cout;
            flags_d.n = hi_sum[UPPER-1];
            flags_d.z = lo_zero_q & hi_zero;
            funct3_d  = tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            flags_q  <= '0;
            funct3_q <= 3'b000;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            flags_q  <= flags_d;
            funct3_q <= funct3_d;
        end
    end

    always_ff @(posedge clk) begin
        lo_diff_q <= lo_diff_d;
        lo_cout_q <= lo_cout_d;
        lo_zero_q <= lo_zero_d;
        a_hi_q    <= a_hi_d;
        b_hi_q    <= b_hi_d;
        tag_q     <= tag_d;
    end

    assign out_valid  = s2_vld_q;
    assign out_flags  = flags_q;
    assign out_funct3 = funct3_q;

endmodule

// File: tb/tb_branch_flag_gen.sv
// Bench for branch_flag_gen: directed flag vectors, backpressure, flush, reset and randomized traffic
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_branch_flag_gen;
    import branch_flag_gen_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      in_funct3;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_flags;
    logic [2:0]      out_funct3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] flags;
        logic [2:0] f3;
    } res_t;

    res_t exp_q[$];

    logic [XLEN-1:0] edge_v[7] = '{32'h0, 32'h1, 32'h7fff_ffff, 32'h8000_0000,
                                   32'hffff_ffff, 32'h0000_ffff, 32'h0001_0000};

    branch_flag_gen #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_funct3  (in_funct3),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flags  (out_flags),
        .out_funct3 (out_funct3)
    );

    always #5 clk = ~clk;

    // Flags from true integer arithmetic: V is set when the exact signed difference
    // differs from the wrapped 32-bit result read back as signed.
    function automatic logic [3:0] ref_flags(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        longint          exact;
        logic [3:0]      f;
        r         = a - b;
        exact     = longint'($signed(a)) - longint'($signed(b));
        f         = 4'b0000;
        f[FLAG_V] = (exact != longint'($signed(r)));
        f[FLAG_C] = (a >= b);
        f[FLAG_N] = r[XLEN-1];
        f[FLAG_Z] = (r == 0);
        return f;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_funct3 = 3'b000;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_flags, out_funct3} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b flags=%b f3=%b want 0/0000/000",
                     out_valid, out_flags, out_funct3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [XLEN-1:0] ta[4] = '{32'd5, 32'h8000_0000, 32'h0, 32'h0001_0000};
        logic [XLEN-1:0] tb[4] = '{32'd5, 32'h1, 32'h1, 32'h0000_ffff};
        logic [2:0]      tf[4] = '{3'b000, 3'b101, 3'b110, 3'b111};
        logic [3:0]      te[4] = '{4'b0101, 4'b1100, 4'b0010, 4'b0100};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_a      = ta[i];
            in_b      = tb[i];
            in_funct3 = tf[i];
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_early_valid got %b want 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({out_valid, out_flags, out_funct3} !== {1'b1, te[i], tf[i]}) begin
                errors++;
                $display("FAIL directed%0d got valid=%b flags=%b f3=%b want 1/%b/%b",
                         i, out_valid, out_flags, out_funct3, te[i], tf[i]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_drain got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   n_acc  = 0;
        int   n_out  = 0;
        logic held   = 1'b0;
        res_t prev_r = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (n_acc < 4);
            in_a      = $urandom;
            in_b      = $urandom;
            in_funct3 = 3'($urandom_range(0, 7));
            #1;
            if (cyc == 2) begin
                checks++;
                if ({in_ready, out_valid} !== 2'b01 || n_acc != 2) begin
                    errors++;
                    $display("FAIL b2b_full got in_ready=%b out_valid=%b accepts=%0d want 0/1/2",
                             in_ready, out_valid, n_acc);
                end
            end
            if (held) begin
                checks++;
                if ({out_valid, out_flags, out_funct3} !== {1'b1, prev_r}) begin
                    errors++;
                    $display("FAIL b2b_hold got %b/%b/%b want 1/%b/%b",
                             out_valid, out_flags, out_funct3, prev_r.flags, prev_r.f3);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || {out_flags, out_funct3} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_result%0d got %b/%b want %b", n_out, out_flags,
                             out_funct3, (exp_q.size() != 0) ? exp_q[0] : 7'bx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({ref_flags(in_a, in_b), in_funct3});
                n_acc++;
            end
            held   = out_valid && !out_ready;
            prev_r = {out_flags, out_funct3};
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (n_out != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d results %0d pending want 4 and 0", n_out, exp_q.size());
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a      = $urandom;
            in_b      = $urandom;
            in_funct3 = 3'b001;
            @(negedge clk);
        end
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_clear got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        // An operand accepted in the same cycle as flush must never surface.
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale cycle%0d got out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h0;
        in_b      = 32'h1;
        in_funct3 = 3'b111;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_flags, out_funct3} !== {1'b1, 4'b0010, 3'b111}) begin
            errors++;
            $display("FAIL rstmid_pre got %b/%b/%b want 1/0010/111", out_valid, out_flags, out_funct3);
        end
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_flags, out_funct3} !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async got %b/%b/%b want 0/0000/000", out_valid, out_flags, out_funct3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale cycle%0d got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic held   = 1'b0;
        res_t prev_r = '0;
        int   mode;
        exp_q.delete();
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 29) == 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                flush     = 1'b0;
            end
            mode = $urandom_range(0, 2);
            in_a = (mode == 0) ? edge_v[$urandom_range(0, 6)] : $urandom;
            in_b = (mode == 1) ? in_a : ((mode == 2) ? edge_v[$urandom_range(0, 6)] : $urandom);
            in_funct3 = 3'($urandom_range(0, 7));
            #1;
            if (held) begin
                checks++;
                if ({out_valid, out_flags, out_funct3} !== {1'b1, prev_r}) begin
                    errors++;
                    $display("FAIL rand_hold cyc%0d got %b/%b/%b want 1/%b/%b", cyc,
                             out_valid, out_flags, out_funct3, prev_r.flags, prev_r.f3);
                end
            end
            if (exp_q.size() == 0 || (out_valid && !out_ready && exp_q.size() == 2)) begin
                checks++;
                if (in_ready !== (exp_q.size() == 0)) begin
                    errors++;
                    $display("FAIL rand_in_ready cyc%0d got %b with %0d in flight", cyc,
                             in_ready, exp_q.size());
                end
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0 || {out_flags, out_funct3} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_result cyc%0d got %b/%b want %b", cyc, out_flags,
                             out_funct3, (exp_q.size() != 0) ? exp_q[0] : 7'bx);
                end
                if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({ref_flags(in_a, in_b), in_funct3});
            held   = out_valid && !out_ready && !flush;
            prev_r = {out_flags, out_funct3};
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain got %0d pending out_valid=%b want 0/0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
